// File: rtl/sparc_exu_regwr_arb.sv
// Shared write-port arbiter for the per-thread EXU state registers.
// Round-robin grant with an age override and a registered, one-cycle write issue.
module sparc_exu_regwr_arb #(
  parameter int unsigned SIZE    = 3,
  parameter int unsigned NREQ    = 3,
  parameter int unsigned MAXWAIT = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [2*NREQ-1:0]    req_thr,
  input  logic [SIZE*NREQ-1:0] req_data,
  input  logic                 wr_stall,
  output logic [NREQ-1:0]      req_gnt,
  output logic                 wen_w,
  output logic [3:0]           thr_w,
  output logic [SIZE-1:0]      data_in_w,
  output logic [3:0]           thr_pend
);

  localparam int unsigned PW   = $clog2(NREQ);
  localparam logic [3:0]  MAXW = 4'(MAXWAIT);

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]      wait_cnt_q [NREQ];
  logic [3:0]      wait_cnt_d [NREQ];
  logic            wen_w_q, wen_w_d;
  logic [3:0]      thr_w_q, thr_w_d;
  logic [SIZE-1:0] data_in_w_q, data_in_w_d;

  logic [1:0]      thr_a  [NREQ];
  logic [SIZE-1:0] data_a [NREQ];
  logic [NREQ-1:0] gnt_raw;
  logic            any_gnt;
  logic [PW-1:0]   win;
  logic [PW-1:0]   scan_idx;
  logic [3:0]      pend_raw;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      thr_a[i]  = req_thr[2*i +: 2];
      data_a[i] = req_data[SIZE*i +: SIZE];
    end
  end

  // Overdue requesters win outright (lowest index); otherwise scan from rr_ptr.
  always_comb begin
    any_gnt  = 1'b0;
    win      = '0;
    scan_idx = '0;
    gnt_raw  = '0;
    if (!wr_stall) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!any_gnt && req_vld[i] && (wait_cnt_q[i] == MAXW)) begin
          any_gnt = 1'b1;
          win     = PW'(i);
        end
      end
      for (int unsigned k = 0; k < NREQ; k++) begin
        scan_idx = PW'((32'(rr_ptr_q) + k) % NREQ);
        if (!any_gnt && req_vld[scan_idx]) begin
          any_gnt = 1'b1;
          win     = scan_idx;
        end
      end
      if (any_gnt) begin
        gnt_raw[win] = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    wen_w_d     = any_gnt;
    thr_w_d     = '0;
    data_in_w_d = data_in_w_q;
    if (any_gnt) begin
      rr_ptr_d    = ((32'(win) + 32'd1) == NREQ) ? '0 : win + 1'b1;
      thr_w_d     = 4'b0001 << thr_a[win];
      data_in_w_d = data_a[win];
    end
  end

  // Age counters freeze during a stall so a stall never promotes a requester.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      wait_cnt_d[i] = wait_cnt_q[i];
      if (!req_vld[i] || gnt_raw[i]) begin
        wait_cnt_d[i] = '0;
      end else if (!wr_stall && (wait_cnt_q[i] < MAXW)) begin
        wait_cnt_d[i] = wait_cnt_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      wen_w_q     <= 1'b0;
      thr_w_q     <= '0;
      data_in_w_q <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        wait_cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wen_w_q     <= wen_w_d;
      thr_w_q     <= thr_w_d;
      data_in_w_q <= data_in_w_d;
      for (int unsigned i = 0; i < NREQ; i++) begin
        wait_cnt_q[i] <= wait_cnt_d[i];
      end
    end
  end

  always_comb begin
    pend_raw = wen_w_q ? thr_w_q : '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_vld[i]) begin
        pend_raw[thr_a[i]] = 1'b1;
      end
    end
  end

  assign req_gnt   = rst ? '0 : gnt_raw;
  assign thr_pend  = rst ? '0 : pend_raw;
  assign wen_w     = wen_w_q;
  assign thr_w     = thr_w_q;
  assign data_in_w = data_in_w_q;

endmodule
